// File: rtl/isqrt_arb_pkg.sv
// Shared types and the round-robin pick helper for the isqrt arbiter.
package isqrt_arb_pkg;

  // Tags are sized for the largest legal requester count so one type serves every N_REQ.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  // First set bit of vld at or above ptr, wrapping modulo n_req; returns ptr when vld is empty.
  function automatic tag_t rr_pick(input logic [MAX_REQ-1:0] vld, input tag_t ptr,
                                   input int unsigned n_req);
    tag_t        pick;
    logic        found;
    int unsigned j;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n_req) j = j - n_req;
      if (k < n_req && !found && vld[j[TAG_W-1:0]]) begin
        pick  = j[TAG_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// Tag FIFO recording the owner of each outstanding isqrt request, in issue order.
module isqrt_tag_fifo
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_data,
  input  logic pop,
  output tag_t pop_data,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_q, rd_q;
  tag_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters, with tagged result routing.
module isqrt_shared_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ*32-1:0]   req_x,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [15:0]           rsp_y,
  output logic                  isqrt_x_vld,
  output logic [31:0]           isqrt_x,
  input  logic                  isqrt_y_vld,
  input  logic [15:0]           isqrt_y,
  output logic                  err_unexpected
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0]      credit_q;
  tag_t               ptr_q;
  logic [MAX_REQ-1:0] vld_ext;
  tag_t               gnt_idx;
  logic               grant_ok;
  logic               transfer;
  logic [31:0]        sel_x;
  logic               pop_en;
  tag_t               pop_tag;
  logic               fifo_empty, fifo_full;

  always_comb begin
    vld_ext = '0;
    vld_ext[N_REQ-1:0] = req_vld;
  end

  assign gnt_idx  = rr_pick(vld_ext, ptr_q, N_REQ);
  // Uses the registered credit, so a return frees a slot only from the following cycle.
  assign grant_ok = (credit_q < CW'(MAX_INFLIGHT));
  assign req_rdy  = (grant_ok && (|req_vld)) ? (N_REQ'(1) << gnt_idx) : '0;
  assign transfer = |(req_vld & req_rdy);
  assign pop_en   = isqrt_y_vld && !fifo_empty;

  always_comb begin
    sel_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == tag_t'(i)) sel_x = req_x[32*i +: 32];
    end
  end

  isqrt_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (transfer),
    .push_data (gnt_idx),
    .pop       (pop_en),
    .pop_data  (pop_tag),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      credit_q       <= '0;
      isqrt_x_vld    <= 1'b0;
      isqrt_x        <= '0;
      rsp_vld        <= '0;
      rsp_y          <= '0;
      err_unexpected <= 1'b0;
    end else begin
      isqrt_x_vld <= transfer;
      if (transfer) begin
        isqrt_x <= sel_x;
        ptr_q   <= (gnt_idx == tag_t'(N_REQ - 1)) ? '0 : gnt_idx + tag_t'(1);
      end
      if (transfer && !pop_en)      credit_q <= credit_q + CW'(1);
      else if (!transfer && pop_en) credit_q <= credit_q - CW'(1);
      rsp_vld <= pop_en ? (N_REQ'(1) << pop_tag) : '0;
      if (pop_en) rsp_y <= isqrt_y;
      // A result with no owner is dropped and flagged until reset.
      if (isqrt_y_vld && fifo_empty) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Directed bench for isqrt_shared_arbiter with a latency-4 isqrt model and a per-requester scoreboard.
module tb_isqrt_shared_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_vld = '0;
  logic [2:0]  lim_vld = '0;
  logic [95:0] req_x = '0;
  logic        spur = 1'b0;

  logic [2:0]  req_rdy, rsp_vld, lim_rdy, lim_rsp_vld;
  logic [15:0] rsp_y, lim_rsp_y;
  logic        err, lim_err;
  logic [1:0]  x_vld, y_vld;
  logic [31:0] x_d [2];
  logic [15:0] y_d [2];
  logic [3:0]  s_v [2];
  logic [15:0] s_y [2][4];

  int checks = 0;
  int errors = 0;
  longint sbq [3][$];

  always #5 clk = ~clk;

  isqrt_shared_arbiter #(.N_REQ(3), .MAX_INFLIGHT(8)) u_dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .isqrt_x_vld(x_vld[0]), .isqrt_x(x_d[0]),
    .isqrt_y_vld(y_vld[0]), .isqrt_y(y_d[0]), .err_unexpected(err)
  );

  isqrt_shared_arbiter #(.N_REQ(3), .MAX_INFLIGHT(2)) u_lim (
    .clk(clk), .rst(rst), .req_vld(lim_vld), .req_x(req_x), .req_rdy(lim_rdy),
    .rsp_vld(lim_rsp_vld), .rsp_y(lim_rsp_y), .isqrt_x_vld(x_vld[1]), .isqrt_x(x_d[1]),
    .isqrt_y_vld(y_vld[1]), .isqrt_y(y_d[1]), .err_unexpected(lim_err)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] root;
    logic [15:0] trial;
    root = '0;
    for (int b = 15; b >= 0; b--) begin
      trial = root | (16'd1 << b);
      if (longint'(trial) * longint'(trial) <= longint'(x)) root = trial;
    end
    return root;
  endfunction

  function automatic longint ref_sqrt(input logic [31:0] x);
    return longint'($floor($sqrt(real'(x))));
  endfunction

  // isqrt model: fixed latency 4, reset together with the arbiters.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) s_v[d] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        s_v[d]    <= {s_v[d][2:0], x_vld[d]};
        s_y[d][0] <= isqrt32(x_d[d]);
        for (int k = 1; k < 4; k++) s_y[d][k] <= s_y[d][k-1];
      end
    end
  end

  assign y_vld[0] = s_v[0][3] | spur;
  assign y_d[0]   = spur ? 16'hBEEF : s_y[0][3];
  assign y_vld[1] = s_v[1][3];
  assign y_d[1]   = s_y[1][3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for u_dut: every response must match the oldest transfer of its owner.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++)
        if (req_vld[i] && req_rdy[i]) sbq[i].push_back(ref_sqrt(req_x[32*i +: 32]));
      if (rsp_vld != 3'b000) begin
        check("rsp_onehot", 64'($countones(rsp_vld)), 64'd1);
        for (int i = 0; i < 3; i++) begin
          if (rsp_vld[i]) begin
            if (sbq[i].size() == 0) check("rsp_unowned", 64'(i), 64'hFF);
            else check("sb_rsp", 64'(rsp_y), 64'(sbq[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_vld = '0;
    lim_vld = '0;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"}, 64'(req_rdy), 64'd0);
    check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'd0);
    check({tag, "_rsp_y"}, 64'(rsp_y), 64'd0);
    check({tag, "_x_vld"}, 64'(x_vld[0]), 64'd0);
    check({tag, "_x"}, 64'(x_d[0]), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] xf;
    int n, cyc;

    // Single request from requester 1, x=144.
    do_reset();
    #1 check_idle("reset");
    req_x[63:32] = 32'd144;
    req_vld = 3'b010;
    #1 check("single_rdy", 64'(req_rdy), 64'b010);
    @(negedge clk);
    req_vld = 3'b000;
    #1 check("single_x_vld", 64'(x_vld[0]), 64'd1);
    check("single_x", 64'(x_d[0]), 64'd144);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      #1 check("single_rsp_early", 64'(rsp_vld), 64'd0);
    end
    @(negedge clk);
    #1 check("single_rsp_vld", 64'(rsp_vld), 64'b010);
    check("single_rsp_y", 64'(rsp_y), 64'd12);
    @(negedge clk);
    #1 check("single_rsp_done", 64'(rsp_vld), 64'd0);

    // Fairness: all requesters held, grants rotate 0,1,2 and results come back in issue order.
    do_reset();
    req_x = {32'd9, 32'd4, 32'd1};
    req_vld = 3'b111;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) req_vld = 3'b000;
      #1;
      check("fair_rdy", 64'(req_rdy), (c < 6) ? 64'(3'b001 << (c % 3)) : 64'd0);
      if (c >= 6) begin
        check("fair_rsp_vld", 64'(rsp_vld), 64'(3'b001 << ((c - 6) % 3)));
        check("fair_rsp_y", 64'(rsp_y), 64'((c - 6) % 3 + 1));
      end
      @(negedge clk);
    end

    // Credit limit of 2 on u_lim: stall until the cycle after the first return.
    do_reset();
    req_x = {32'd9, 32'd4, 32'd1};
    lim_vld = 3'b111;
    for (int c = 0; c < 9; c++) begin
      logic [2:0] er, ev;
      logic [15:0] ey;
      er = 3'b000; ev = 3'b000; ey = 16'd0;
      case (c)
        0: er = 3'b001;
        1: er = 3'b010;
        6: begin er = 3'b100; ev = 3'b001; ey = 16'd1; end
        7: begin er = 3'b001; ev = 3'b010; ey = 16'd2; end
        default: ;
      endcase
      #1;
      check("lim_rdy", 64'(lim_rdy), 64'(er));
      check("lim_rsp_vld", 64'(lim_rsp_vld), 64'(ev));
      if (ev != 3'b000) check("lim_rsp_y", 64'(lim_rsp_y), 64'(ey));
      @(negedge clk);
    end
    lim_vld = 3'b000;

    // Full throughput: push and pop every cycle once the pipeline fills.
    do_reset();
    req_x = {32'hFFFF_FFFF, 32'd0, 32'd1};
    req_vld = 3'b111;
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 3000) begin
      #1;
      check("tp_rdy_nonzero", 64'(req_rdy != 3'b000), 64'd1);
      xf = req_vld & req_rdy;
      if (xf != 3'b000) n++;
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (xf[i]) req_x[32*i +: 32] = $urandom;
    end
    check("tp_count", 64'(n), 64'd1000);
    req_vld = 3'b000;
    repeat (10) @(negedge clk);
    #1 check("tp_drained", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);

    // Spurious result with nothing outstanding.
    do_reset();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1 check("spur_rsp_vld", 64'(rsp_vld), 64'd0);
    check("spur_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    #1 check("spur_rsp_later", 64'(rsp_vld), 64'd0);
    check("spur_err_sticky", 64'(err), 64'd1);

    // Reset with three requests outstanding, then a fresh request from requester 2.
    do_reset();
    req_x = {32'd9, 32'd4, 32'd1};
    req_vld = 3'b111;
    repeat (3) @(negedge clk);
    req_vld = 3'b000;
    rst = 1'b1;
    #1 check_idle("midrst");
    @(negedge clk);
    #1 check_idle("midrst_next");
    rst = 1'b0;
    req_x[95:64] = 32'd25;
    req_vld = 3'b100;
    #1 check("post_rdy", 64'(req_rdy), 64'b100);
    @(negedge clk);
    req_vld = 3'b000;
    repeat (4) begin
      @(negedge clk);
      #1 check("post_rsp_early", 64'(rsp_vld), 64'd0);
    end
    @(negedge clk);
    #1 check("post_rsp_vld", 64'(rsp_vld), 64'b100);
    check("post_rsp_y", 64'(rsp_y), 64'd5);
    check("post_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
